// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle fetch/decode/execute control FSM with retired-instruction counter
module mc_ctrl #(
    parameter int CNT_W = 32,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op,
    input  logic [OP_W-1:0]  funct,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             memwr,
    output logic             irwr,
    output logic             pcwr,
    output logic [1:0]       npcctrl,
    output logic             regwr,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             alusrc,
    output logic [1:0]       aluctrl,
    output logic [1:0]       extop,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_ACC  = 4'd6,
        S_WB_MEM   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    state_t cur, nxt;

    logic is_rtype, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_rtype = (op == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_ori   = (op == 6'b001101);
    assign is_lui   = (op == 6'b001111);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);

    logic imem_req_c, dmem_req_c, memwr_c, irwr_c, pcwr_c, regwr_c, illegal_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (pcwr_c)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        nxt        = cur;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        memwr_c    = 1'b0;
        irwr_c     = 1'b0;
        pcwr_c     = 1'b0;
        regwr_c    = 1'b0;
        illegal_c  = 1'b0;
        npcctrl    = 2'b00;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrc     = 1'b0;
        aluctrl    = 2'b00;
        extop      = 2'b00;
        case (cur)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    irwr_c = 1'b1;
                    nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_addu || is_subu)     nxt = S_EXEC_R;
                else if (is_ori || is_lui)  nxt = S_EXEC_I;
                else if (is_lw || is_sw)    nxt = S_MEM_ADDR;
                else if (is_beq)            nxt = S_BRANCH;
                else if (is_j || is_jal)    nxt = S_JUMP;
                else begin
                    // Unknown encodings retire as a NOP so the PC still advances.
                    illegal_c = 1'b1;
                    pcwr_c    = 1'b1;
                    nxt       = S_FETCH;
                end
            end
            S_EXEC_R: begin
                aluctrl = is_subu ? 2'b01 : 2'b00;
                nxt     = S_WB_ALU;
            end
            S_EXEC_I: begin
                alusrc  = 1'b1;
                aluctrl = is_lui ? 2'b11 : 2'b10;
                extop   = is_lui ? 2'b10 : 2'b00;
                nxt     = S_WB_ALU;
            end
            S_WB_ALU: begin
                // ALU controls held so the result stays valid through writeback.
                if (is_rtype) begin
                    aluctrl = is_subu ? 2'b01 : 2'b00;
                    regdst  = 2'b01;
                end else begin
                    alusrc  = 1'b1;
                    aluctrl = is_lui ? 2'b11 : 2'b10;
                    extop   = is_lui ? 2'b10 : 2'b00;
                end
                regwr_c = 1'b1;
                pcwr_c  = 1'b1;
                nxt     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alusrc = 1'b1;
                extop  = 2'b01;
                nxt    = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                alusrc     = 1'b1;
                extop      = 2'b01;
                dmem_req_c = 1'b1;
                memwr_c    = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        pcwr_c = 1'b1;
                        nxt    = S_FETCH;
                    end else begin
                        nxt = S_WB_MEM;
                    end
                end
            end
            S_WB_MEM: begin
                regwr_c  = 1'b1;
                memtoreg = 2'b01;
                pcwr_c   = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                aluctrl = 2'b01;
                extop   = 2'b01;
                pcwr_c  = 1'b1;
                npcctrl = 2'b01;
                nxt     = S_FETCH;
            end
            S_JUMP: begin
                pcwr_c  = 1'b1;
                npcctrl = 2'b10;
                if (is_jal) begin
                    regwr_c  = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                end
                nxt = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        if (rst) begin
            imem_req_c = 1'b0;
            dmem_req_c = 1'b0;
            memwr_c    = 1'b0;
            irwr_c     = 1'b0;
            pcwr_c     = 1'b0;
            regwr_c    = 1'b0;
            illegal_c  = 1'b0;
        end
    end

    assign imem_req = imem_req_c;
    assign dmem_req = dmem_req_c;
    assign memwr    = memwr_c;
    assign irwr     = irwr_c;
    assign pcwr     = pcwr_c;
    assign regwr    = regwr_c;
    assign illegal  = illegal_c;
    assign state    = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a per-instruction trace model
module tb_mc_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, memwr, irwr, pcwr, regwr, alusrc, illegal;
    logic [1:0] npcctrl, regdst, memtoreg, aluctrl, extop;
    logic [CNT_W-1:0] instret;
    logic [3:0] state;

    mc_ctrl #(.CNT_W(CNT_W), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .memwr(memwr), .irwr(irwr),
        .pcwr(pcwr), .npcctrl(npcctrl), .regwr(regwr), .regdst(regdst),
        .memtoreg(memtoreg), .alusrc(alusrc), .aluctrl(aluctrl), .extop(extop),
        .illegal(illegal), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        ir;
        logic        dr;
        logic        z;
        logic [17:0] ctl;
    } cyc_t;

    cyc_t q[$];
    int pass_cnt = 0;
    int total = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    // Expected control word: imem_req,dmem_req,memwr,irwr,pcwr,npcctrl,regwr,regdst,memtoreg,alusrc,aluctrl,extop,illegal
    function automatic logic [17:0] o(int imreq, int dreq, int mw, int irw, int pcw, int npc,
                                      int rw, int rd, int m2r, int asrc, int actl, int ext, int ill);
        logic [31:0] n, r, m, a, e;
        n = npc; r = rd; m = m2r; a = actl; e = ext;
        return {imreq[0], dreq[0], mw[0], irw[0], pcw[0], n[1:0], rw[0], r[1:0], m[1:0],
                asrc[0], a[1:0], e[1:0], ill[0]};
    endfunction

    function automatic logic [17:0] dut_ctl();
        return {imem_req, dmem_req, memwr, irwr, pcwr, npcctrl, regwr, regdst, memtoreg,
                alusrc, aluctrl, extop, illegal};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 illegal
    function automatic int classify(logic [5:0] o_op, logic [5:0] o_fn);
        case (o_op)
            6'b000000: return (o_fn == 6'b100001) ? 0 : (o_fn == 6'b100011) ? 1 : 9;
            6'b001101: return 2;
            6'b001111: return 3;
            6'b100011: return 4;
            6'b101011: return 5;
            6'b000100: return 6;
            6'b000010: return 7;
            6'b000011: return 8;
            default:   return 9;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add(int st, logic ir, logic dr, logic z, logic [17:0] c);
        cyc_t e;
        e.st = 4'(st); e.ir = ir; e.dr = dr; e.z = z; e.ctl = c;
        q.push_back(e);
    endtask

    // Build the cycle-by-cycle trace one instruction must produce.
    task automatic gen(logic [5:0] g_op, logic [5:0] g_fn, int iw, int dw, logic z);
        int cls;
        int a, e;
        cls = classify(g_op, g_fn);
        for (int i = 0; i < iw; i++) add(0, 1'b0, rb(), rb(), o(1,0,0,0,0,0,0,0,0,0,0,0,0));
        add(0, 1'b1, rb(), rb(), o(1,0,0,1,0,0,0,0,0,0,0,0,0));
        if (cls == 9) begin
            add(1, rb(), rb(), rb(), o(0,0,0,0,1,0,0,0,0,0,0,0,1));
            return;
        end
        add(1, rb(), rb(), rb(), o(0,0,0,0,0,0,0,0,0,0,0,0,0));
        case (cls)
            0, 1: begin
                a = cls;
                add(2, rb(), rb(), rb(), o(0,0,0,0,0,0,0,0,0,0,a,0,0));
                add(4, rb(), rb(), rb(), o(0,0,0,0,1,0,1,1,0,0,a,0,0));
            end
            2, 3: begin
                a = (cls == 2) ? 2 : 3;
                e = (cls == 2) ? 0 : 2;
                add(3, rb(), rb(), rb(), o(0,0,0,0,0,0,0,0,0,1,a,e,0));
                add(4, rb(), rb(), rb(), o(0,0,0,0,1,0,1,0,0,1,a,e,0));
            end
            4, 5: begin
                add(5, rb(), rb(), rb(), o(0,0,0,0,0,0,0,0,0,1,0,1,0));
                for (int i = 0; i < dw; i++)
                    add(6, rb(), 1'b0, rb(), o(0,1,(cls==5),0,0,0,0,0,0,1,0,1,0));
                add(6, rb(), 1'b1, rb(), o(0,1,(cls==5),0,(cls==5),0,0,0,0,1,0,1,0));
                if (cls == 4) add(7, rb(), rb(), rb(), o(0,0,0,0,1,0,1,0,1,0,0,0,0));
            end
            6: add(8, rb(), rb(), z, o(0,0,0,0,1,1,0,0,0,0,1,1,0));
            7: add(9, rb(), rb(), rb(), o(0,0,0,0,1,2,0,0,0,0,0,0,0));
            default: add(9, rb(), rb(), rb(), o(0,0,0,0,1,2,1,2,2,0,0,0,0));
        endcase
    endtask

    // Single compare point: every queued cycle is checked at the falling edge.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            imem_ready = c.ir; dmem_ready = c.dr; zero = c.z;
            @(negedge clk);
            check("state", 64'(state), 64'(c.st));
            check("ctl", 64'(dut_ctl()), 64'(c.ctl));
            check("instret", 64'(instret), 64'(exp_ret));
            if (c.ctl[13]) exp_ret++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_instr(logic [5:0] d_op, logic [5:0] d_fn, int iw, int dw, logic z, int exp_len);
        op = d_op; funct = d_fn;
        gen(d_op, d_fn, iw, dw, z);
        if (exp_len >= 0) check("latency", 64'(q.size()), 64'(exp_len));
        run_queue();
    endtask

    logic [5:0] r_op, r_fn;
    int sel;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ready = rb(); dmem_ready = rb();
            @(negedge clk);
            check("reset_strobes", 64'({imem_req, dmem_req, memwr, irwr, pcwr, regwr, illegal}), 64'd0);
        end
        check("reset_state", 64'(state), 64'd0);
        check("reset_instret", 64'(instret), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_instr(6'b000000, 6'b100001, 0, 0, 1'b0, 4);
        check("instret_after_addu", 64'(instret), 64'd1);
        do_instr(6'b100011, 6'h00, 0, 3, 1'b0, 8);
        do_instr(6'b000100, 6'h00, 0, 0, 1'b1, 3);
        do_instr(6'b000100, 6'h00, 0, 0, 1'b0, 3);
        do_instr(6'b000011, 6'h00, 0, 0, 1'b0, 3);
        do_instr(6'b000010, 6'h00, 0, 0, 1'b0, 3);
        do_instr(6'b111111, 6'h00, 0, 0, 1'b0, 2);
        do_instr(6'b000000, 6'b000000, 1, 0, 1'b0, 3);
        do_instr(6'b101011, 6'h00, 0, 0, 1'b0, 4);
        do_instr(6'b001111, 6'h00, 0, 0, 1'b0, 4);
        check("instret_directed", 64'(instret), 64'd10);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            r_fn = 6'($urandom);
            case (sel)
                0: begin r_op = 6'b000000; r_fn = 6'b100001; end
                1: begin r_op = 6'b000000; r_fn = 6'b100011; end
                2: r_op = 6'b001101;
                3: r_op = 6'b001111;
                4: r_op = 6'b100011;
                5: r_op = 6'b101011;
                6: r_op = 6'b000100;
                7: r_op = 6'b000010;
                8: r_op = 6'b000011;
                default: begin
                    r_op = 6'($urandom);
                    while (classify(r_op, r_fn) != 9) begin
                        r_op = 6'($urandom);
                        r_fn = 6'($urandom);
                    end
                end
            endcase
            do_instr(r_op, r_fn, $urandom_range(0, 3), $urandom_range(0, 3), rb(), -1);
        end

        // Abort a stalled sw with a one-cycle reset.
        op = 6'b101011; funct = '0;
        gen(6'b101011, 6'h00, 0, 5, 1'b0);
        q = q[0:3];
        run_queue();
        rst = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        check("abort_strobes", 64'({imem_req, dmem_req, memwr, irwr, pcwr, regwr, illegal}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; dmem_ready = 1'b0;
        exp_ret = '0;
        @(negedge clk);
        check("abort_state", 64'(state), 64'd0);
        check("abort_instret", 64'(instret), 64'd0);
        check("abort_imem_req", 64'({imem_req, pcwr, memwr}), 64'b100);
        @(posedge clk); #1;
        do_instr(6'b000000, 6'b100011, 0, 0, 1'b0, 4);
        check("instret_after_abort", 64'(instret), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the fetch/decode/execute datapath around the next-PC unit, register file, ALU and memories. It commits each instruction with exactly one PC write. On that cycle it drives the npcctrl select so that nextpc is computed from the PC of the instruction being retired. Memory accesses use a req/ready handshake with unbounded wait states.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_W, 6, opcode/funct field width (fixed 6; parameter for documentation only)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
op  input  6  IR[31:26], stable from DECODE through commit
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, combinational, same cycle
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
memwr  output  1  data memory write strobe (qualified by dmem_req)
irwr  output  1  IR load enable
pcwr  output  1  PC load enable (commit)
npcctrl  output  2  00 pc+4, 01 branch-if-zero, 10 jump
regwr  output  1  register file write enable
regdst  output  2  00 rt, 01 rd, 10 $31
memtoreg  output  2  00 ALU, 01 mem data, 10 pc_4
alusrc  output  1  0 reg B, 1 extended immediate
aluctrl  output  2  00 add, 01 sub, 10 or, 11 lui
extop  output  2  00 zero-ext, 01 sign-ext, 10 upper
illegal  output  1  one-cycle pulse on unrecognised opcode
instret  output  CNT_W  count of committed instructions
state  output  4  current FSM state (debug)

Behaviour:
- Decode: R-type op=000000 with funct addu=100001 / subu=100011. Other immediate opcodes: ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
- States (encoding): FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, WB_ALU=4, MEM_ADDR=5, MEM_ACC=6, WB_MEM=7, BRANCH=8, JUMP=9.
- Outputs are combinational from state, op and funct. Any output not listed for a state is 0.
- FETCH: imem_req=1. If imem_ready, irwr=1 and go to DECODE; otherwise stay.
- DECODE: no strobes. Transitions:
  - addu/subu -> EXEC_R
  - ori/lui -> EXEC_I
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - j/jal -> JUMP
  - anything else (including unknown funct): illegal=1, pcwr=1, npcctrl=00 (NOP commit), -> FETCH
- EXEC_R: alusrc=0, aluctrl = 00 (addu) or 01 (subu) -> WB_ALU.
- EXEC_I: alusrc=1.
  - ori: aluctrl=10, extop=00.
  - lui: aluctrl=11, extop=10.
  - Then -> WB_ALU.
- WB_ALU: holds the EXEC ALU controls, regwr=1, memtoreg=00, pcwr=1, npcctrl=00 -> FETCH.
  - regdst: 01 for R-type, 00 for immediates.
- MEM_ADDR: alusrc=1, extop=01, aluctrl=00 -> MEM_ACC.
- MEM_ACC: holds the address controls, dmem_req=1, memwr=1 for sw.
  - Stays while dmem_ready=0.
  - sw with ready: pcwr=1, npcctrl=00 -> FETCH.
  - lw with ready -> WB_MEM.
- WB_MEM: regwr=1, regdst=00, memtoreg=01, pcwr=1, npcctrl=00 -> FETCH.
- BRANCH: alusrc=0, aluctrl=01, extop=01, pcwr=1, npcctrl=01 -> FETCH.
  - The taken/not-taken choice is made by the next-PC unit from the zero flag in this same cycle.
- JUMP: pcwr=1, npcctrl=10.
  - jal: also regwr=1, regdst=10, memtoreg=10.
  - Then -> FETCH.
- Latency (ready=1 every cycle): R/I 4 cycles, lw 5, sw 4, beq 3, j/jal 3, illegal 2.
- Invariants:
  - pcwr is asserted exactly once per instruction.
  - instret increments on every cycle with pcwr=1, including illegal, and wraps modulo 2^CNT_W.
- Reset (rst=1 at a clock edge, from any state, including mid memory wait): state=FETCH and instret=0.
  - While rst is high, all strobes (imem_req, dmem_req, memwr, irwr, pcwr, regwr, illegal) are forced 0.
  - The first imem_req is issued in the cycle after rst deasserts.
  - A dmem_ready arriving during reset is ignored.
- Ready asserted in a state that does not request it is ignored.

Test Plan:
- Reset, then addu (op=0, funct=100001) with imem_ready=1: states 0,1,2,4. Only cycle 4 has regwr=1, regdst=01, pcwr=1, npcctrl=00. instret=1.
- lw (100011) with dmem_ready low for 3 cycles: MEM_ACC held 4 cycles with dmem_req=1 and memwr=0. WB_MEM has memtoreg=01 and pcwr=1. Total 8 cycles.
- beq (000100) with zero=1, then again with zero=0: both take 3 cycles. BRANCH cycle has npcctrl=01, pcwr=1, aluctrl=01, and no regwr.
- jal (000011): JUMP cycle has npcctrl=10, regwr=1, regdst=10, memtoreg=10. j (000010) gives the same with regwr=0.
- op=111111: illegal=1 for exactly one cycle in DECODE, pcwr=1, npcctrl=00, back in FETCH next cycle, instret incremented.
- sw with dmem_ready=0 and rst pulsed for one cycle: next state FETCH, memwr=0 during reset, instret=0, and no pcwr for the aborted sw.
